// File: rtl/alu_mul_sequencer_pkg.sv
// Shared constants for the shift-add multiply sequencer.
// ALU operation codes and the datapath width used by the sequencer.
package alu_mul_sequencer_pkg;

   localparam int RV_XLEN  = 32;
   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD    = 4'h0;
   localparam logic [ALU_OP_W-1:0] ALU_LSL    = 4'h5;
   localparam logic [ALU_OP_W-1:0] ALU_PASS_1 = 4'hF;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle RV32M MUL (low bits) built by sequencing an external alu
// through an add / shift-left loop over the multiplier bits.
module alu_mul_sequencer
   import alu_mul_sequencer_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int OP_W = ALU_OP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_in_0,
   output logic [XLEN-1:0] alu_in_1,
   output logic [OP_W-1:0] alu_operation,
   input  logic [XLEN-1:0] alu_out
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_mcand;
   logic [XLEN-1:0] r_mplier;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_result;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] w_mplier_sh;
   logic            w_last;

   assign w_mplier_sh = r_mplier >> 1;
   // Stop early once no multiplier bits remain, or after the final bit.
   assign w_last      = (w_mplier_sh == '0) ||
                        (r_count == CW'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_mcand  <= in_a;
                  r_mplier <= in_b;
                  r_acc    <= '0;
                  r_count  <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_ADD;
               end
            end
            S_ADD: begin
               if (r_mplier[0])
                  r_acc <= alu_out;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_mcand  <= alu_out;
               r_mplier <= w_mplier_sh;
               r_count  <= r_count + 1'b1;
               if (w_last) begin
                  r_result <= r_acc;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_state <= S_ADD;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      alu_operation = OP_W'(ALU_PASS_1);
      alu_in_0      = '0;
      alu_in_1      = '0;
      unique case (r_state)
         S_ADD: begin
            alu_operation = OP_W'(ALU_ADD);
            alu_in_0      = r_acc;
            alu_in_1      = r_mcand;
         end
         S_SHIFT: begin
            alu_operation = OP_W'(ALU_LSL);
            alu_in_0      = r_mcand;
            alu_in_1      = XLEN'(1);
         end
         default: ;
      endcase
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural alu alongside
// and a queue scoreboard of expected products and done latencies.
module tb_alu_mul_sequencer;
   import alu_mul_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] alu_in_0;
   logic [31:0] alu_in_1;
   logic [3:0]  alu_operation;
   logic [31:0] alu_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] q_res[$];
   int          q_lat[$];

   always #5 clk = ~clk;

   alu_mul_sequencer #(.XLEN(32), .OP_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .in_a          (in_a),
      .in_b          (in_b),
      .busy          (busy),
      .done          (done),
      .result        (result),
      .alu_in_0      (alu_in_0),
      .alu_in_1      (alu_in_1),
      .alu_operation (alu_operation),
      .alu_out       (alu_out)
   );

   always_comb begin
      alu_out = '0;
      case (alu_operation)
         4'h0:    alu_out = alu_in_0 + alu_in_1;
         4'h5:    alu_out = alu_in_0 << alu_in_1[4:0];
         4'hF:    alu_out = alu_in_1;
         default: alu_out = '0;
      endcase
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input bit chk_ops,
                         input int inj);
      int          cyc;
      int          n;
      int          lat;
      logic [31:0] er;
      bit          seen;
      n = 1;
      for (int i = 0; i < 32; i++)
         if (b[i]) n = i + 1;
      q_res.push_back(a * b);
      q_lat.push_back(2 * n + 1);
      @(negedge clk);
      start = 1'b1;
      in_a  = a;
      in_b  = b;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      seen  = 1'b0;
      while (cyc < 200) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (cyc == inj) begin
            start = 1'b1;
            in_a  = 32'd9;
            in_b  = 32'd9;
         end else begin
            start = 1'b0;
         end
         check("busy", 32'(busy), 32'd1);
         if (chk_ops)
            check("op_seq", 32'(alu_operation),
                  (cyc % 2 == 1) ? 32'(ALU_ADD) : 32'(ALU_LSL));
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      er  = q_res.pop_front();
      lat = q_lat.pop_front();
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(cyc), 32'(lat));
      check("result", result, er);
      check("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("result_hold", result, er);
   endtask

   initial begin
      bit spurious;
      rst   = 1'b1;
      start = 1'b0;
      in_a  = '0;
      in_b  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_op", 32'(alu_operation), 32'(ALU_PASS_1));
      check("rst_in0", alu_in_0, 32'd0);
      rst = 1'b0;

      run_op(32'd5, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FFFE, 32'd7, 1'b0, 0);
      run_op(32'h1234, 32'd0, 1'b0, 0);
      run_op(32'd0, 32'h8000_0000, 1'b0, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'd5, 32'd7, 1'b0, 3);
      run_op(32'd9, 32'd9, 1'b0, 0);

      // Abort a 5 x 7 with reset in cycle 4.
      @(negedge clk);
      start = 1'b1;
      in_a  = 32'd5;
      in_b  = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      spurious = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) spurious = 1'b1;
      end
      check("abort_no_done", 32'(spurious), 32'd0);
      run_op(32'd3, 32'd3, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low XLEN bits of in_a × in_b (RV32M MUL semantics) by sequencing the existing alu block.
- Uses the alu's ALU_ADD and ALU_LSL operations in a shift-add loop.
- Owns the alu's operand and operation inputs while busy; the core stalls on busy and takes result when done pulses.

Parameters:
- XLEN, 32, datapath width; matches the XLEN constant in riscv.h.
- OP_W, 4, width of the alu operation code.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- in_a  in  XLEN  multiplicand; sampled on the accepted start.
- in_b  in  XLEN  multiplier; sampled on the accepted start.
- busy  out  1  high from the cycle after acceptance until done is high.
- done  out  1  one-cycle pulse; result is valid in the same cycle.
- result  out  XLEN  product low bits; held until the next done.
- alu_in_0  out  XLEN  to alu in_0.
- alu_in_1  out  XLEN  to alu in_1.
- alu_operation  out  OP_W  to alu operation.
- alu_out  in  XLEN  from alu out, combinational in the same cycle.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; busy = 0, done = 0, result = 0.
  - Internal acc, mcand, mplier and count are cleared.
  - Reset during any state aborts the operation. No done is issued and the old result is lost (result = 0).
- States: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - Drive alu_operation = ALU_PASS_1, alu_in_0 = 0, alu_in_1 = 0.
  - On start = 1: mcand <= in_a, mplier <= in_b, acc <= 0, count <= 0, then go to ADD.
- ADD:
  - Drive alu_operation = ALU_ADD, alu_in_0 = acc, alu_in_1 = mcand.
  - If mplier[0] = 1, acc <= alu_out; otherwise acc holds.
  - Go to SHIFT.
- SHIFT:
  - Drive alu_operation = ALU_LSL, alu_in_0 = mcand, alu_in_1 = 1.
  - mcand <= alu_out, mplier <= mplier >> 1 (logical), count <= count + 1.
  - If (mplier >> 1) == 0 or count == XLEN-1, go to DONE; otherwise go to ADD.
- DONE:
  - done = 1, busy = 0, result <= acc (visible in the same cycle, i.e. result is driven from acc in DONE and registered thereafter).
  - ALU is driven as in IDLE. Go to IDLE.
  - A start asserted while in DONE is ignored.
- busy = 1 in ADD and SHIFT only. start is ignored whenever state ≠ IDLE; there is no queueing.
- Latency: let n = max(1, index of the highest set bit of in_b + 1). With the accepting cycle counted as cycle 0, done is high in cycle 2n+1.
  - in_b = 0 gives done at cycle 3, result 0.
  - in_b with bit XLEN-1 set gives done at cycle 2·XLEN+1.
- Arithmetic: all sums wrap modulo 2^XLEN and there is no overflow flag. Signed and unsigned operands give the same low bits.
- The alu zero output is unused.
- count width is clog2(XLEN).

Decomposition:
- ALU_ADD, ALU_LSL and ALU_PASS_1 come from the shared alu_codes.h; XLEN comes from riscv.h. No new shared constants.
- State encoding is local to the module.
- No sub-module. The alu is instantiated outside, next to the sequencer.
- The bench uses a small wrapper, mul_unit, that instantiates alu_mul_sequencer with alu.

Test Plan:
- Start with in_a = 5, in_b = 7 → done at cycle 7, result = 35, busy high in cycles 1–6.
- Start with in_a = -2, in_b = 7 → result = 0xFFFFFFF2, done at cycle 7.
- Start with in_a = 0x1234, in_b = 0 → done at cycle 3, result = 0. Then start with in_a = 0, in_b = 0x80000000 → done at cycle 65, result = 0.
- Start with in_a = 0xFFFFFFFF, in_b = 0xFFFFFFFF → result = 0x00000001, done at cycle 65. Check alu_operation alternates ALU_ADD / ALU_LSL in cycles 1–64.
- 5 × 7 in progress, start pulsed again at cycle 3 with in_a = 9, in_b = 9 → ignored, result = 35 at cycle 7; next start from IDLE with 9 × 9 → 81.
- 5 × 7 in progress, rst at cycle 4 → next cycle busy = 0, done = 0, result = 0. No done pulse follows, and a subsequent 3 × 3 gives 9 at cycle 5.
